// File: rtl/aes_128_dec_core.sv
// rtl/aes_128_dec_core.sv - iterative AES-128 inverse cipher, one round per clock, on-chip key expansion
// Define AES_DEC_STATS_EN to add the blk_cnt output-block counter.
module aes_128_dec_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         din_valid,
  input  logic [127:0] din,
  output logic         din_ready,
  output logic         dout_valid,
  output logic [127:0] dout,
  input  logic         dout_ready,
  output logic         key_loaded
`ifdef AES_DEC_STATS_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);
  typedef enum logic [2:0] {NOKEY, KEYEXP, READY, ROUND, OUT} state_e;

  state_e       fsm_q;
  logic [3:0]   round_cnt_q;
  logic [127:0] rk_q [0:10];
  logic [127:0] state_q, dout_q;
  logic         key_ready_q, rdy_q, dout_valid_q, key_loaded_q;
  logic         key_hs, din_hs;
  logic [127:0] rk_prev, rk_d, shifted, subbed, ark, mixed, round_d;
  logic [31:0]  rot_word, sub_word, t_word;
  logic [7:0]   rcon;
`ifdef AES_DEC_STATS_EN
  logic [31:0]  blk_cnt_q;
  assign blk_cnt = blk_cnt_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign key_ready  = key_ready_q;
  assign din_ready  = rdy_q & ~key_valid;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign key_loaded = key_loaded_q;
  assign key_hs     = key_valid & key_ready_q;
  assign din_hs     = din_valid & din_ready;

  // Key schedule step: rk[n] from rk[n-1], Rcon selected by round_cnt
  assign rk_prev  = rk_q[round_cnt_q - 4'd1];
  assign rot_word = {rk_prev[23:0], rk_prev[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_ksb
    aes_sbox u_sbox (.a_i(rot_word[31-8*i -: 8]), .y_o(sub_word[31-8*i -: 8]));
  end
  assign t_word = sub_word ^ {rcon, 24'h0};
  assign rk_d[127:96] = rk_prev[127:96] ^ t_word;
  assign rk_d[95:64]  = rk_prev[95:64]  ^ rk_d[127:96];
  assign rk_d[63:32]  = rk_prev[63:32]  ^ rk_d[95:64];
  assign rk_d[31:0]   = rk_prev[31:0]   ^ rk_d[63:32];

  always_comb begin
    rcon = 8'h00;
    case (round_cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Byte b sits at row b%4, column b/4; row r rotates right by r
  for (genvar b = 0; b < 16; b++) begin : g_isb
    localparam int SRC = 4 * ((((b / 4) - (b % 4)) + 4) % 4) + (b % 4);
    assign shifted[127-8*b -: 8] = state_q[127-8*SRC -: 8];
    aes_inv_sbox u_inv_sbox (.a_i(shifted[127-8*b -: 8]), .y_o(subbed[127-8*b -: 8]));
  end
  assign ark = subbed ^ rk_q[round_cnt_q];
  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end
  assign round_d = (round_cnt_q == 4'd0) ? ark : mixed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= NOKEY;
      round_cnt_q  <= 4'd0;
      state_q      <= '0;
      dout_q       <= '0;
      key_ready_q  <= 1'b0;
      rdy_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      key_loaded_q <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
`ifdef AES_DEC_STATS_EN
      blk_cnt_q    <= '0;
`endif
    end else begin
      case (fsm_q)
        NOKEY: begin
          key_ready_q <= ~key_hs;
          if (key_hs) begin
            rk_q[0]     <= key;
            round_cnt_q <= 4'd1;
            fsm_q       <= KEYEXP;
          end
        end
        KEYEXP: begin
          rk_q[round_cnt_q] <= rk_d;
          if (round_cnt_q == 4'd10) begin
            key_loaded_q <= 1'b1;
            key_ready_q  <= 1'b1;
            rdy_q        <= 1'b1;
            fsm_q        <= READY;
          end else begin
            round_cnt_q <= round_cnt_q + 4'd1;
          end
        end
        READY: begin
          if (key_hs) begin
            rk_q[0]      <= key;
            round_cnt_q  <= 4'd1;
            key_loaded_q <= 1'b0;
            key_ready_q  <= 1'b0;
            rdy_q        <= 1'b0;
            fsm_q        <= KEYEXP;
          end else if (din_hs) begin
            state_q     <= din ^ rk_q[10];
            round_cnt_q <= 4'd9;
            key_ready_q <= 1'b0;
            rdy_q       <= 1'b0;
            fsm_q       <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_d;
          if (round_cnt_q == 4'd0) begin
            dout_q       <= round_d;
            dout_valid_q <= 1'b1;
            fsm_q        <= OUT;
          end else begin
            round_cnt_q <= round_cnt_q - 4'd1;
          end
        end
        OUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            rdy_q        <= 1'b1;
            fsm_q        <= READY;
          end
        end
        default: fsm_q <= NOKEY;
      endcase
`ifdef AES_DEC_STATS_EN
      if (key_hs) blk_cnt_q <= '0;
      else if (fsm_q == OUT && dout_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
`endif
    end
  end
endmodule

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y_o = SBOX[a_i];
endmodule

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign y_o = ISBOX[a_i];
endmodule

// File: tb/tb_aes_128_dec_core.sv
// tb/tb_aes_128_dec_core.sv - scoreboard bench for aes_128_dec_core against a byte-level AES model
module tb_aes_128_dec_core;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         key_valid = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [127:0] key = '0, din = '0;
  logic         key_ready, din_ready, dout_valid, key_loaded;
  logic [127:0] dout;
`ifdef AES_DEC_STATS_EN
  logic [31:0]  blk_cnt;
  int           blk_exp = 0;
`endif
  int           checks = 0, errors = 0, cyc = 0, acc_cyc = 0, last_out_cyc = 0, rdy_mode = 0;
  logic [127:0] exp_q [$];
  int           cyc_q [$];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] cur_key = '0, held_d = '0, ct;
  logic         held_v = 1'b0;
  int           t_key;

  aes_128_dec_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key        (key),
    .key_ready  (key_ready),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready),
    .key_loaded (key_loaded)
`ifdef AES_DEC_STATS_EN
    ,
    .blk_cnt    (blk_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return (v << 1) ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map
  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = x[7:0];
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] c);
    logic [31:0]  w [44];
    logic [7:0]   st [4][4];
    logic [7:0]   tmp [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   rc, acc;
    logic [31:0]  t;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int cc = 0; cc < 4; cc++)
      for (int r = 0; r < 4; r++)
        st[r][cc] = c[127-8*(4*cc+r) -: 8] ^ w[40+cc][31-8*r -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++)
          tmp[r][cc] = isb[st[r][(cc - r + 4) % 4]] ^ w[4*rnd+cc][31-8*r -: 8];
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++) begin
          if (rnd == 0) st[r][cc] = tmp[r][cc];
          else begin
            acc = 8'h00;
            for (int kk = 0; kk < 4; kk++) acc ^= gmul(coef[(kk - r + 4) % 4], tmp[kk][cc]);
            st[r][cc] = acc;
          end
        end
    end
    for (int cc = 0; cc < 4; cc++)
      for (int r = 0; r < 4; r++) res[127-8*(4*cc+r) -: 8] = st[r][cc];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [127:0] k);
    bit ok;
    int t;
    @(posedge clk); #1;
    key = k;
    key_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_ready) begin ok = 1; break; end
    end
    chk("key_accept", ok, 1);
    t = cyc;
    @(posedge clk); #1;
    key_valid = 1'b0;
    cur_key = k;
`ifdef AES_DEC_STATS_EN
    blk_exp = 0;
`endif
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_loaded) begin ok = 1; break; end
    end
    chk("key_loaded", ok, 1);
    // counted in clock edges after the edge that accepted the key
    chk("key_lat", cyc - (t + 1), 10);
  endtask

  task automatic send(input logic [127:0] c, input logic [127:0] expv);
    bit ok;
    @(posedge clk); #1;
    din = c;
    din_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1; break; end
    end
    chk("din_accept", ok, 1);
    if (ok) begin
      exp_q.push_back(expv);
      cyc_q.push_back(cyc);
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ($urandom_range(3) != 0);
        default: dout_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on each new output, stability under backpressure, scoreboard on handshake
  always @(negedge clk) begin
    if (!rst_n) held_v = 1'b0;
    else begin
      if (held_v) begin
        chk("bp_dout", dout, held_d);
        chk("bp_valid", dout_valid, 1);
        chk("bp_din_ready", din_ready, 0);
      end else if (dout_valid) begin
        if (cyc_q.size() == 0) chk("spurious_dout", dout_valid, 0);
        else chk("dout_latency", cyc - cyc_q[0], 11);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() > 0) begin
          chk("dout", dout, exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
        last_out_cyc = cyc;
        held_v = 1'b0;
`ifdef AES_DEC_STATS_EN
        blk_exp++;
`endif
      end else if (dout_valid) begin
        held_v = 1'b1;
        held_d = dout;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    build_tables();
    repeat (3) @(negedge clk);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_key_loaded", key_loaded, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("nokey_key_ready", key_ready, 1);

    rdy_mode = 0;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      ct = rand128();
      send(ct, model_dec(cur_key, ct));
    end
    drain();
    load_key(rand128());
    for (int i = 0; i < 4; i++) begin
      ct = rand128();
      send(ct, model_dec(cur_key, ct));
    end
    drain();

    rdy_mode = 2;
    ct = rand128();
    send(ct, model_dec(cur_key, ct));
    for (int i = 0; i < 100 && !dout_valid; i++) @(negedge clk);
    chk("bp_out_seen", dout_valid, 1);
    @(posedge clk); #1;
    ct = rand128();
    din = ct;
    din_valid = 1'b1;
    repeat (20) @(negedge clk);
    rdy_mode = 0;
    send(ct, model_dec(cur_key, ct));
    chk("bp_second_after_hs", (acc_cyc > last_out_cyc) && (last_out_cyc > 0), 1);
    drain();

    @(posedge clk); #1;
    key = rand128();
    key_valid = 1'b1;
    ct = rand128();
    din = ct;
    din_valid = 1'b1;
    @(negedge clk);
    chk("both_din_ready", din_ready, 0);
    chk("both_key_ready", key_ready, 1);
    t_key = cyc;
    @(posedge clk); #1;
    key_valid = 1'b0;
    cur_key = key;
`ifdef AES_DEC_STATS_EN
    blk_exp = 0;
`endif
    send(ct, model_dec(cur_key, ct));
    chk("both_data_after_exp", acc_cyc - t_key, 11);
    drain();

    ct = rand128();
    send(ct, model_dec(cur_key, ct));
    while (cyc < acc_cyc + 6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_key_ready", key_ready, 0);
    chk("mid_din_ready", din_ready, 0);
    chk("mid_dout_valid", dout_valid, 0);
    chk("mid_dout", dout, 0);
    chk("mid_key_loaded", key_loaded, 0);
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_key_ready", key_ready, 1);
    chk("post_rst_key_loaded", key_loaded, 0);
    repeat (15) @(negedge clk);
    load_key(rand128());
    for (int i = 0; i < 2; i++) begin
      ct = rand128();
      send(ct, model_dec(cur_key, ct));
    end
    drain();

`ifdef AES_DEC_STATS_EN
    load_key(rand128());
    chk("blk_cnt_clear", blk_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      ct = rand128();
      send(ct, model_dec(cur_key, ct));
    end
    drain();
    chk("blk_cnt_three", blk_cnt, 3);
    chk("blk_cnt_model", blk_cnt, blk_exp);
    load_key(rand128());
    chk("blk_cnt_new_key", blk_cnt, 0);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
